// File: rtl/lcd_bus_if.sv
// Character-LCD parallel bus (ON/RW/EN/RS/DATA) between an LCD driver (master)
// and the responder that mimics the panel (slave).
interface lcd_bus_if;
    logic       lcd_on;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_rs;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (
        output lcd_on, lcd_rw, lcd_en, lcd_rs, lcd_data_in,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  lcd_on, lcd_rw, lcd_en, lcd_rs, lcd_data_in,
        output lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/lcd_bus_responder.sv
// HD44780-style 16x2 panel model: 32-char buffer, command decode, busy flag.
// Define LCD_RESP_READ_EN to support status/data read cycles.
module lcd_bus_responder #(
    parameter int BUSY_SHORT = 1850,
    parameter int BUSY_LONG  = 76000   // must exceed 32 so CLEAR finishes inside it
) (
    input  logic       clk,
    input  logic       rst,
    lcd_bus_if.slave   bus,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [4:0] cursor,
    output logic       display_on,
    output logic       busy,
    output logic       proto_err
);

    localparam int CW = $clog2((BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT);

    typedef enum logic [1:0] {IDLE, CLEAR, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [7:0]    mem [32];
    logic          en_q;
    logic          fall_q;
    logic          rw_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          inc_mode;
    logic [4:0]    clr_idx;

    function automatic logic [4:0] step(input logic [4:0] c, input logic inc);
        return inc ? (c + 5'd1) : (c - 5'd1);
    endfunction

    assign rd_char = mem[rd_addr];

`ifdef LCD_RESP_READ_EN
    logic [6:0] addr_code;
    // Line 2 lives at DDRAM 0x40..0x4F on the real panel.
    assign addr_code        = {cursor[4], 2'b00, cursor[3:0]};
    assign bus.lcd_data_oe  = bus.lcd_rw & bus.lcd_en & bus.lcd_on;
    assign bus.lcd_data_out = !bus.lcd_data_oe ? 8'h00 :
                              bus.lcd_rs       ? mem[cursor] : {busy, addr_code};
`else
    assign bus.lcd_data_oe  = 1'b0;
    assign bus.lcd_data_out = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
            state      <= IDLE;
            count      <= '0;
            en_q       <= 1'b0;
            fall_q     <= 1'b0;
            rw_q       <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            inc_mode   <= 1'b1;
            clr_idx    <= 5'd0;
            cursor     <= 5'd0;
            display_on <= 1'b0;
            busy       <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            en_q <= bus.lcd_en;
            if (bus.lcd_en) begin
                rw_q   <= bus.lcd_rw;
                rs_q   <= bus.lcd_rs;
                data_q <= bus.lcd_data_in;
            end
            // Registering the fall gives a clean one-cycle pulse acting on held fields.
            fall_q <= en_q & ~bus.lcd_en & bus.lcd_on;

            if (fall_q) begin
                if (rw_q) begin
`ifdef LCD_RESP_READ_EN
                    if (rs_q) cursor <= step(cursor, inc_mode);
`else
                    proto_err <= 1'b1;
`endif
                end else if (busy) begin
                    proto_err <= 1'b1;
                end else begin
                    busy  <= 1'b1;
                    state <= BUSY;
                    count <= CW'(BUSY_SHORT - 1);
                    if (rs_q) begin
                        mem[cursor] <= data_q;
                        cursor      <= step(cursor, inc_mode);
                    end else begin
                        casez (data_q)
                            8'b1???????: begin
                                if (data_q[6:4] == 3'b000)
                                    cursor <= {1'b0, data_q[3:0]};
                                else if (data_q[6:4] == 3'b100)
                                    cursor <= {1'b1, data_q[3:0]};
                                else
                                    proto_err <= 1'b1;
                            end
                            8'b0001????: if (!data_q[3]) cursor <= step(cursor, data_q[2]);
                            8'b00001???: display_on <= data_q[2];
                            8'b000001??: inc_mode <= data_q[1];
                            8'b0000001?: begin
                                cursor <= 5'd0;
                                count  <= CW'(BUSY_LONG - 1);
                            end
                            8'b00000001: begin
                                state   <= CLEAR;
                                clr_idx <= 5'd0;
                                count   <= CW'(BUSY_LONG - 1);
                            end
                            default: ;
                        endcase
                    end
                end
            end

            // Sits after the fall handling so the end of CLEAR wins over a read step.
            case (state)
                CLEAR: begin
                    mem[clr_idx] <= 8'h20;
                    clr_idx      <= clr_idx + 5'd1;
                    count        <= count - 1'b1;
                    if (clr_idx == 5'd31) begin
                        state    <= BUSY;
                        cursor   <= 5'd0;
                        inc_mode <= 1'b1;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with shortened busy times (20 / 50 cycles).
module tb_lcd_bus_responder;

    localparam int BS = 20;
    localparam int BL = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [4:0] cursor;
    logic       display_on;
    logic       busy;
    logic       proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_bus_if bus();

    lcd_bus_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .cursor     (cursor),
        .display_on (display_on),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(tag, {24'h0, rd_char}, {24'h0, exp});
    endtask

    task automatic check_all_blank(input string tag);
        for (int i = 0; i < 32; i++) peek(tag, 5'(i), 8'h20);
    endtask

    task automatic bus_cycle(input logic rw, input logic rs, input logic [7:0] d);
        bus.lcd_rw = rw;
        bus.lcd_rs = rs;
        bus.lcd_data_in = d;
        bus.lcd_en = 1'b1;
        @(negedge clk);
        bus.lcd_en = 1'b0;
        bus.lcd_rw = 1'b0;
    endtask

    task automatic write(input logic rs, input logic [7:0] d);
        bus_cycle(1'b0, rs, d);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        rd_addr = 5'd0;
        bus.lcd_on = 1'b1;
        bus.lcd_rw = 1'b0;
        bus.lcd_en = 1'b0;
        bus.lcd_rs = 1'b0;
        bus.lcd_data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_all_blank("reset_buf");
        check("reset_cursor", {27'h0, cursor}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_err", {31'h0, proto_err}, 32'h0);
        check("reset_disp", {31'h0, display_on}, 32'h0);
        check("reset_oe", {31'h0, bus.lcd_data_oe}, 32'h0);

        // Display on, busy length, first character
        write(1'b0, 8'h0C);
        check("disp_on", {31'h0, display_on}, 32'h1);
        cnt = 0;
        while (busy && cnt < 500) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_short_len", cnt, BS);
        write(1'b1, 8'h41);
        peek("buf0_A", 5'd0, 8'h41);
        check("cursor_after_A", {27'h0, cursor}, 32'd1);
        wait_idle();

        // Line addressing
        write(1'b0, 8'hC5);
        check("cursor_C5", {27'h0, cursor}, 32'd21);
        wait_idle();
        write(1'b1, 8'h5A);
        peek("buf21_Z", 5'd21, 8'h5A);
        check("cursor_after_Z", {27'h0, cursor}, 32'd22);
        wait_idle();
        write(1'b0, 8'h8F);
        check("cursor_8F", {27'h0, cursor}, 32'd15);
        wait_idle();
        write(1'b1, 8'h51);
        peek("buf15_Q", 5'd15, 8'h51);
        check("cursor_after_Q", {27'h0, cursor}, 32'd16);
        wait_idle();

        // Decrement entry mode and cursor shift
        write(1'b0, 8'h04);
        wait_idle();
        write(1'b1, 8'h43);
        peek("buf16_C", 5'd16, 8'h43);
        check("cursor_dec", {27'h0, cursor}, 32'd15);
        wait_idle();
        write(1'b0, 8'h14);
        check("cursor_shift_r", {27'h0, cursor}, 32'd16);
        wait_idle();
        check("err_before_clear", {31'h0, proto_err}, 32'h0);

        // Clear with a write dropped during busy
        write(1'b0, 8'h01);
        check("clear_busy", {31'h0, busy}, 32'h1);
        write(1'b1, 8'h77);
        cnt = 3;
        check("drop_err", {31'h0, proto_err}, 32'h1);
        check("drop_cursor", {27'h0, cursor}, 32'd16);
        while (busy && cnt < 500) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_long_len", cnt, BL);
        check_all_blank("clear_buf");
        check("clear_cursor", {27'h0, cursor}, 32'h0);
        write(1'b1, 8'h42);
        peek("buf0_B", 5'd0, 8'h42);
        check("clear_id_reset", {27'h0, cursor}, 32'd1);
        wait_idle();

        // Reset mid-CLEAR
        write(1'b0, 8'h01);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, proto_err}, 32'h0);
        check("rst_disp", {31'h0, display_on}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_after", {31'h0, busy}, 32'h0);
        check("rst_cursor", {27'h0, cursor}, 32'h0);
        check_all_blank("rst_buf");

        // Panel off: transfers ignored
        bus.lcd_on = 1'b0;
        write(1'b1, 8'h55);
        check("off_cursor", {27'h0, cursor}, 32'h0);
        check("off_busy", {31'h0, busy}, 32'h0);
        peek("off_buf0", 5'd0, 8'h20);
        bus.lcd_on = 1'b1;
        @(negedge clk);

        // Invalid DDRAM address
        write(1'b0, 8'h90);
        check("bad_addr_err", {31'h0, proto_err}, 32'h1);
        check("bad_addr_cursor", {27'h0, cursor}, 32'h0);
        wait_idle();

        do_reset();
`ifdef LCD_RESP_READ_EN
        write(1'b0, 8'hC1);
        check("cursor_C1", {27'h0, cursor}, 32'd17);
        bus.lcd_rw = 1'b1;
        bus.lcd_rs = 1'b0;
        bus.lcd_en = 1'b1;
        #1;
        check("status_out", {24'h0, bus.lcd_data_out}, 32'hC1);
        check("status_oe", {31'h0, bus.lcd_data_oe}, 32'h1);
        @(negedge clk);
        bus.lcd_en = 1'b0;
        bus.lcd_rw = 1'b0;
        #1;
        check("idle_out", {24'h0, bus.lcd_data_out}, 32'h0);
        repeat (2) @(negedge clk);
        check("status_cursor", {27'h0, cursor}, 32'd17);
        check("status_err", {31'h0, proto_err}, 32'h0);
        wait_idle();
        write(1'b0, 8'hCF);
        wait_idle();
        write(1'b1, 8'h58);
        check("wrap_inc", {27'h0, cursor}, 32'h0);
        wait_idle();
        write(1'b0, 8'hCF);
        wait_idle();
        bus.lcd_rw = 1'b1;
        bus.lcd_rs = 1'b1;
        bus.lcd_en = 1'b1;
        #1;
        check("data_read_out", {24'h0, bus.lcd_data_out}, 32'h58);
        check("data_read_oe", {31'h0, bus.lcd_data_oe}, 32'h1);
        @(negedge clk);
        bus.lcd_en = 1'b0;
        bus.lcd_rw = 1'b0;
        repeat (2) @(negedge clk);
        check("read_wrap", {27'h0, cursor}, 32'h0);
        check("read_no_busy", {31'h0, busy}, 32'h0);
        check("read_err", {31'h0, proto_err}, 32'h0);
`else
        bus.lcd_rw = 1'b1;
        bus.lcd_rs = 1'b1;
        bus.lcd_en = 1'b1;
        #1;
        check("noread_oe", {31'h0, bus.lcd_data_oe}, 32'h0);
        check("noread_out", {24'h0, bus.lcd_data_out}, 32'h0);
        @(negedge clk);
        bus.lcd_en = 1'b0;
        bus.lcd_rw = 1'b0;
        repeat (2) @(negedge clk);
        check("noread_err", {31'h0, proto_err}, 32'h1);
        check("noread_cursor", {27'h0, cursor}, 32'h0);
        check("noread_busy", {31'h0, busy}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

Device-side responder for the 16x2 character-LCD parallel bus (ON/RW/EN/RS/DATA[7:0]) that our LCD driver blocks initiate on. It decodes the HD44780-style command subset our drivers emit, keeps a 32-character display buffer, models the busy flag, and answers read cycles. It mirrors the panel in simulation and on-chip, so quiz/display logic can be checked without the physical LCD.

## Interface

Parameters:
- BUSY_SHORT, 1850: busy cycles after a normal command or data access (37 us at 50 MHz).
- BUSY_LONG, 76000: busy cycles after clear or home (1.52 ms at 50 MHz).

Ports:
- clk  in  1  system clock; the same clock the bus initiator runs on.
- rst  in  1  asynchronous, active-high reset.
- lcd_on  in  1  panel power; bus transfers are ignored while 0.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_en  in  1  strobe; a transfer is accepted on its falling edge.
- lcd_rs  in  1  0 = command/status, 1 = data.
- lcd_data_in  in  8  bus value driven by the initiator.
- lcd_data_out  out  8  value this block drives on read cycles.
- lcd_data_oe  out  1  tristate enable for lcd_data_out.
- rd_addr  in  5  snoop index into the buffer (0–15 line 1, 16–31 line 2).
- rd_char  out  8  buffer content at rd_addr, combinational.
- cursor  out  5  current address counter.
- display_on  out  1  D bit from display control.
- busy  out  1  busy flag.
- proto_err  out  1  sticky error flag; cleared only by reset.

## Operation

Strobe capture:
- en_q registers lcd_en. A fall is en_q=1 and lcd_en=0.
- rw, rs and data are registered every cycle while lcd_en=1. A fall acts on the values from the last high cycle.

Acceptance rules:
- Falls with lcd_on=0 are ignored and have no effect.
- A write fall while busy=1 is dropped and sets proto_err.
- Read falls are always accepted.

Command decoding (write with rs=0), by the highest set bit:
- 1xxxxxxx, set DDRAM address:
  - bits[6:0] 0x00–0x0F map to cursor 0–15.
  - bits[6:0] 0x40–0x4F map to cursor 16–31.
  - Any other address sets proto_err and leaves cursor unchanged.
- 01xxxxxx, CGRAM address: no state change.
- 001xxxxx, function set: no state change.
- 0001 S/C R/L xx, shift:
  - With S/C=0, cursor moves +1 if R/L=1, otherwise −1, with wrap.
  - With S/C=1 there is no change.
- 00001 D C B, display control: display_on <= D.
- 000001 I/D S, entry mode: the I/D bit is stored (reset value 1). S is ignored.
- 0000001x, return home: cursor <= 0. Busy time is BUSY_LONG.
- 00000001, clear:
  - Enters CLEAR, which writes 0x20 to entries 0..31, one per cycle (32 cycles).
  - Then cursor <= 0 and I/D <= 1.
  - Busy time is BUSY_LONG counted from the fall; CLEAR completes within it.
- 00000000: no-op.

Data and read accesses:
- Data write (rs=1): buf[cursor] <= data, then cursor steps per I/D.
- Status read (rw=1, rs=0): drives {busy, addr_code[6:0]}; state is unchanged. addr_code is cursor for 0–15 and 0x40+(cursor−16) for 16–31.
- Data read (rw=1, rs=1): drives buf[cursor]; cursor steps per I/D on the fall.

Cursor and bus output:
- Stepping wraps 31→0 on increment and 0→31 on decrement.
- lcd_data_oe = lcd_rw & lcd_en & lcd_on, combinational from the pins.

State machine: IDLE → BUSY (any accepted non-clear access), IDLE → CLEAR (clear command) → BUSY → IDLE when the counter expires.

Reset values:
- All buffer entries 0x20, cursor 0, I/D 1, display_on 0.
- busy 0, proto_err 0, state IDLE, counter 0.
- lcd_data_oe follows its pin equation; lcd_data_out is 0x00 when not driving.

## Timing

- A fall is detected 1 cycle after lcd_en goes low. Buffer, cursor and busy update on the next edge, so the effect is visible 2 cycles after lcd_en deasserts.
- busy rises 2 cycles after the fall and stays high for exactly BUSY_SHORT or BUSY_LONG cycles (counter loaded with N−1, down to 0).
- Reads do not start a busy period.
- Read data is valid while lcd_en=1; it is the combinational value of the current state.
- rst asserted mid-CLEAR or mid-BUSY aborts immediately to reset values; no partial state is retained.
- If a fall and the busy expiry occur in the same cycle, busy counts as still set: a write is dropped and flagged.

## Configuration

- LCD_RESP_READ_EN defined: read cycles are supported as above.
- LCD_RESP_READ_EN undefined:
  - lcd_data_oe is tied to 0.
  - Any read fall sets proto_err and has no other effect.
  - The read mux is removed.

## Test plan

- Reset, then snoop all rd_addr values → rd_char=0x20 everywhere, cursor=0, busy=0, proto_err=0.
- Command 0x0C then data 'A' (0x41) after busy clears → display_on=1, buf[0]=0x41, cursor=1; busy high for exactly BUSY_SHORT cycles.
- Command 0xC5, write 'Z', then 0x8F, write 'Q' → buf[21]=0x5A and cursor=22; buf[15]=0x51 and cursor=16. Command 0x90 → proto_err=1.
- Write a 0x01 clear, then issue a write while busy → after 32 cycles all entries 0x20; the dropped write leaves the buffer unchanged and sets proto_err. busy lasts BUSY_LONG.
- With the macro defined: status read during busy, cursor=17 → lcd_data_out=0xC1, oe=1. A data read at cursor 31 with I/D=1 returns buf[31] and wraps cursor to 0.
- Assert rst mid-CLEAR → state IDLE, busy=0, buffer all 0x20 on the next cycle.
